// File: rtl/inst_encoder_pkg.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg
// Shared definitions for the RV32I instruction encoder / program writer:
//   - kind_e      : request class encodings carried on req_kind
//   - OP_*        : RV32I major opcodes emitted by the encoder
//   - F3_*        : funct3 values forced for LW / SW / JALR
//   - NOP_WORD    : addi x0,x0,0, used as filler when NOP padding is built in
//   - imm_fits()  : true when imm[31:msb] are all equal (value fits as signed)
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_R       = 3'd0,
    KIND_I_ALU   = 3'd1,
    KIND_SHIFT_I = 3'd2,
    KIND_LW      = 3'd3,
    KIND_SW      = 3'd4,
    KIND_BRANCH  = 3'd5,
    KIND_JAL     = 3'd6,
    KIND_JALR    = 3'd7
  } kind_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // funct7 value selecting SUB / SRA / SRAI
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_STD = 7'b0000000;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct3 values with special meaning in the legality checks
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // An arithmetic right shift by msb leaves all zeros or all ones exactly
  // when every bit from msb upward matches, i.e. the value sign-extends
  // cleanly from bit msb.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] w_shifted;
    w_shifted = 32'($signed(imm) >>> msb);
    return (w_shifted == 32'h0000_0000) || (w_shifted == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// -----------------------------------------------------------------------------
// inst_enc_fifo
// Small synchronous first-word-fall-through FIFO holding encoded words.
// The head entry is visible combinationally so the writer can present it on
// the memory port in the cycle after it was pushed.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   W      entry width
// Ports:
//   clk      in   clock, rising edge
//   i_srst   in   synchronous active-high reset, empties the FIFO
//   i_push   in   write i_data (ignored when full)
//   i_data   in   entry to push
//   i_pop    in   drop the head entry (ignored when empty)
//   o_head   out  current head entry (undefined content while empty)
//   o_full   out  all DEPTH entries occupied
//   o_empty  out  no entries occupied
// -----------------------------------------------------------------------------
module inst_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         i_srst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];

  // One extra pointer bit distinguishes full from empty when the index bits
  // coincide.
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign o_head = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// RV32I instruction encoder and instruction-memory program writer. Field-level
// requests are assembled into 32-bit RV32I words, queued in inst_enc_fifo and
// written to instruction memory at an auto-incrementing word address.
//
// Build option:
//   INST_ENC_NOP_PAD_EN  when defined, an illegal request queues the NOP word
//                        0x00000013 so written addresses stay aligned with the
//                        request sequence. When undefined, illegal requests
//                        are dropped. err is set in both builds.
//
// Parameters:
//   ADDR_W  instruction-memory word-address width
//   DEPTH   FIFO entries (power of two, >= 2)
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   synchronous reset, ACTIVE HIGH despite the name
//   req_valid   in   request present
//   req_ready   out  request can be accepted
//   req_kind    in   0 R,1 I_ALU,2 SHIFT_I,3 LW,4 SW,5 BRANCH,6 JAL,7 JALR
//   req_funct3  in   funct3 (forced for LW/SW/JALR, unused for JAL)
//   req_alt     in   funct7[5] for R and SHIFT_I
//   req_rd/rs1/rs2 in register indices
//   req_imm     in   byte-offset immediate, two's complement
//   base_load   in   load write address from base_addr
//   base_addr   in   new write address
//   mem_we      out  write strobe (FIFO not empty)
//   mem_addr    out  write word address
//   mem_wdata   out  encoded instruction at FIFO head
//   mem_ready   in   memory accepts the write this cycle
//   err         out  sticky illegal-request flag
//   wr_count    out  writes since reset, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [15:0]       wr_count
);

`ifdef INST_ENC_NOP_PAD_EN
  localparam logic NOP_PAD = 1'b1;
`else
  localparam logic NOP_PAD = 1'b0;
`endif

  kind_e       w_kind;
  logic [31:0] w_word;
  logic        w_legal;
  logic [6:0]  w_funct7;

  logic        w_accept;
  logic        w_push;
  logic [31:0] w_push_data;
  logic        w_pop;
  logic [31:0] w_head;
  logic        w_full;
  logic        w_empty;

  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [15:0]       r_wr_count;

  assign w_kind   = kind_e'(req_kind);
  assign w_funct7 = req_alt ? FUNCT7_ALT : FUNCT7_STD;

  // ---------------------------------------------------------------------------
  // Encoding and legality
  // ---------------------------------------------------------------------------
  always_comb begin
    w_word  = NOP_WORD;
    w_legal = 1'b0;
    case (w_kind)
      KIND_R: begin
        w_word  = {w_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
        // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
        w_legal = ~req_alt || (req_funct3 == F3_ADD_SUB) || (req_funct3 == F3_SRL_SRA);
      end
      KIND_I_ALU: begin
        w_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I_ALU};
        w_legal = imm_fits(req_imm, 11);
      end
      KIND_SHIFT_I: begin
        // Shift amount is unsigned 5 bits; funct7 sits above it.
        w_word  = {w_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_I_ALU};
        w_legal = (req_imm[31:5] == 27'd0) &&
                  ((req_funct3 == F3_SLL) || (req_funct3 == F3_SRL_SRA)) &&
                  (~req_alt || (req_funct3 == F3_SRL_SRA));
      end
      KIND_LW: begin
        w_word  = {req_imm[11:0], req_rs1, F3_LW, req_rd, OP_LOAD};
        w_legal = imm_fits(req_imm, 11);
      end
      KIND_SW: begin
        w_word  = {req_imm[11:5], req_rs2, req_rs1, F3_SW, req_imm[4:0], OP_STORE};
        w_legal = imm_fits(req_imm, 11);
      end
      KIND_BRANCH: begin
        // B-type scrambles the halfword offset: bit 12, 10:5 up top, 4:1 and
        // 11 in the rd slot.
        w_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                   req_imm[4:1], req_imm[11], OP_BRANCH};
        w_legal = imm_fits(req_imm, 12) && ~req_imm[0] &&
                  (req_funct3 != F3_BR_RSV0) && (req_funct3 != F3_BR_RSV1);
      end
      KIND_JAL: begin
        w_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                   req_rd, OP_JAL};
        w_legal = imm_fits(req_imm, 20) && ~req_imm[0];
      end
      KIND_JALR: begin
        w_word  = {req_imm[11:0], req_rs1, F3_JALR, req_rd, OP_JALR};
        w_legal = imm_fits(req_imm, 11);
      end
      default: begin
        w_word  = NOP_WORD;
        w_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // Readiness depends only on fullness, so a pop in the same cycle never
  // frees a slot for a push.
  assign req_ready = ~w_full & ~rstn;
  assign w_accept  = req_valid & req_ready;

  // Illegal requests are always consumed; they reach the FIFO only as a NOP
  // filler when padding is built in.
  assign w_push      = w_accept & (w_legal | NOP_PAD);
  assign w_push_data = w_legal ? w_word : NOP_WORD;

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .i_srst  (rstn),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Memory writer
  // ---------------------------------------------------------------------------
  // The strobe is held off while reset is asserted so queued entries being
  // discarded never reach memory.
  assign mem_we    = ~w_empty & ~rstn;
  assign w_pop     = mem_we & mem_ready;
  assign mem_addr  = r_addr;
  // Head storage is unreset, so present zero rather than stale data when idle.
  assign mem_wdata = w_empty ? 32'h0000_0000 : w_head;

  assign err      = r_err;
  assign wr_count = r_wr_count;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_wr_count <= 16'd0;
    end else begin
      // A base load wins over the increment from a same-cycle write.
      if (base_load) begin
        r_addr <= base_addr;
      end else if (w_pop) begin
        r_addr <= r_addr + 1'b1;
      end

      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end

      if (w_pop && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder. Expected memory writes are pushed to a
// scoreboard queue when each request is accepted and popped by a monitor when
// the DUT strobes a write to memory. Build with INST_ENC_NOP_PAD_EN defined to
// expect NOP filler writes for illegal requests.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_encoder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  localparam logic [2:0] K_R      = 3'd0;
  localparam logic [2:0] K_I_ALU  = 3'd1;
  localparam logic [2:0] K_SHIFT  = 3'd2;
  localparam logic [2:0] K_LW     = 3'd3;
  localparam logic [2:0] K_SW     = 3'd4;
  localparam logic [2:0] K_BRANCH = 3'd5;
  localparam logic [2:0] K_JAL    = 3'd6;
  localparam logic [2:0] K_JALR   = 3'd7;

  localparam logic [31:0] EXP_NOP = 32'h0000_0013;

  logic              clk;
  logic              rstn;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [2:0]        req_funct3;
  logic              req_alt;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              err;
  logic [15:0]       wr_count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } sb_entry_t;

  sb_entry_t         sb[$];
  sb_entry_t         mon_e;
  logic [ADDR_W-1:0] exp_addr;
  int                exp_wr;
  int                n_chk;
  int                n_fail;

  inst_encoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_funct3 (req_funct3),
    .req_alt    (req_alt),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .base_load  (base_load),
    .base_addr  (base_addr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .err        (err),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] word, input bit legal);
    if (legal) begin
      sb.push_back('{exp_addr, word});
      exp_addr = exp_addr + 1'b1;
      exp_wr++;
    end else begin
`ifdef INST_ENC_NOP_PAD_EN
      sb.push_back('{exp_addr, EXP_NOP});
      exp_addr = exp_addr + 1'b1;
      exp_wr++;
`endif
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accept edge so
  // consecutive calls give back-to-back requests.
  task automatic send(input logic [2:0] kind, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp_word, input bit legal);
    int waited;
    req_valid  = 1'b1;
    req_kind   = kind;
    req_funct3 = f3;
    req_alt    = alt;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
    waited     = 0;
    @(negedge clk);
    while (!req_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      step();
      return;
    end
    @(posedge clk);
    sb_push(exp_word, legal);
    $display("req  kind=%0d f3=%0d alt=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%08h legal=%0d",
             kind, f3, alt, rd, rs1, rs2, imm, legal);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    step();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Write monitor: every strobe that memory accepts must match the scoreboard.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("mem_wdata", mem_wdata, mon_e.data);
        $display("write addr=0x%03h data=0x%08h", mem_addr, mem_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] r_imm12;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [2:0]  r_f3;

    n_chk      = 0;
    n_fail     = 0;
    exp_addr   = '0;
    exp_wr     = 0;
    rstn       = 1'b1;
    req_valid  = 1'b0;
    req_kind   = '0;
    req_funct3 = '0;
    req_alt    = 1'b0;
    req_rd     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_imm    = '0;
    base_load  = 1'b0;
    base_addr  = '0;
    mem_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_wr_count",  32'(wr_count),  32'd0);
    step();
    rstn = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    step();

    // addi x1,x0,5 with one-cycle accept-to-write latency
    send(K_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    idle();
    @(negedge clk);
    chk("latency_mem_we", 32'(mem_we), 32'd1);
    step();
    drain();

    // Back-to-back mix of classes
    send(K_R,      3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h4020_81B3, 1'b1);
    send(K_SW,     3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423, 1'b1);
    send(K_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b1);
    send(K_SHIFT,  3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3,          32'h4033_5293, 1'b1);
    send(K_LW,     3'b111, 1'b0, 5'd3, 5'd2, 5'd0, 32'd4,          32'h0041_2183, 1'b1);
    send(K_JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h0080_00EF, 1'b1);
    send(K_JALR,   3'b110, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,          32'h0000_8067, 1'b1);
    for (int k = 0; k < 4; k++) begin
      r_imm12 = 12'($urandom_range(0, 4095));
      r_rd    = 5'($urandom_range(0, 31));
      r_rs1   = 5'($urandom_range(0, 31));
      r_f3    = 3'($urandom_range(0, 7));
      send(K_I_ALU, r_f3, 1'b0, r_rd, r_rs1, 5'd0, {{20{r_imm12[11]}}, r_imm12},
           {r_imm12, r_rs1, r_f3, r_rd, 7'b0010011}, 1'b1);
    end
    idle();
    drain();
    chk("err_clean", 32'(err), 32'd0);

    // Backpressure: four requests fill the FIFO, the fifth waits
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(K_I_ALU, 3'b000, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 16),
           {12'(k + 16), 5'd0, 3'b000, 5'(k + 1), 7'b0010011}, 1'b1);
    end
    idle();
    @(negedge clk);
    chk("full_ready_low", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("hold_mem_we",   32'(mem_we),   32'd1);
    chk("hold_mem_addr", 32'(mem_addr), 32'(sb[0].addr));
    chk("hold_mem_data", mem_wdata,     sb[0].data);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ready_before_pop", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_pop", 32'(req_ready), 32'd1);
    step();
    send(K_I_ALU, 3'b000, 1'b0, 5'd9, 5'd0, 5'd0, 32'd99, 32'h0630_0493, 1'b1);
    idle();
    drain();
    chk("wr_count_mid", 32'(wr_count), 32'(exp_wr));

    // Illegal requests: odd JAL offset, oversize shift, reserved branch funct3
    send(K_JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3,  32'd0, 1'b0);
    idle();
    drain();
    chk("err_set", 32'(err), 32'd1);
    chk("wr_count_after_jal", 32'(wr_count), 32'(exp_wr));
    send(K_SHIFT,  3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 32'd0, 1'b0);
    send(K_BRANCH, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,  32'd0, 1'b0);
    send(K_R,      3'b001, 1'b1, 5'd1, 5'd1, 5'd2, 32'd0,  32'd0, 1'b0);
    idle();
    drain();
    chk("wr_count_after_illegal", 32'(wr_count), 32'(exp_wr));
    chk("addr_after_illegal",     32'(mem_addr), 32'(exp_addr));

    // Reset mid-burst discards queued entries
    mem_ready = 1'b0;
    send(K_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b1);
    send(K_I_ALU, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b1);
    idle();
    rstn = 1'b1;
    sb.delete();
    exp_addr = '0;
    exp_wr   = 0;
    step();
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_we",   32'(mem_we),    32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr),  32'd0);
    chk("mid_rst_wr_count", 32'(wr_count),  32'd0);
    chk("mid_rst_err",      32'(err),       32'd0);
    chk("mid_rst_ready",    32'(req_ready), 32'd1);
    step();
    mem_ready = 1'b1;
    repeat (3) step();

    // Base load and address wrap
    base_load = 1'b1;
    base_addr = 10'h3FF;
    exp_addr  = 10'h3FF;
    step();
    base_load = 1'b0;
    send(K_I_ALU, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd7, 32'h0070_0393, 1'b1);
    send(K_I_ALU, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8, 32'h0080_0413, 1'b1);
    idle();
    drain();
    chk("base_wr_count", 32'(wr_count), 32'd2);
    chk("base_wrap_addr", 32'(mem_addr), 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction encoder and instruction-memory program writer: the inverse of the core's control decoder. It accepts field-level instruction requests (class, funct3, alt bit, register indices, immediate) over a valid/ready handshake. Each request is assembled into a 32-bit RV32I word, buffered in a small FIFO, and written to instruction memory at an auto-incrementing word address. It is used for boot-time program loading and self-test stimulus generation.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-high (asserted = 1)
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_kind  in  3  0 R, 1 I_ALU, 2 SHIFT_I, 3 LW, 4 SW, 5 BRANCH, 6 JAL, 7 JALR
- req_funct3  in  3  funct3 (ignored for LW/SW/JAL/JALR, which force 010/010/-/000)
- req_alt  in  1  funct7[5] (R: SUB/SRA; SHIFT_I: SRAI)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  byte-offset immediate, two's complement
- base_load  in  1  load write address from base_addr
- base_addr  in  ADDR_W  new write address
- mem_we  out  ADDR_W-independent 1  write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- err  out  1  sticky illegal-request flag
- wr_count  out  16  instructions written since reset, saturating

## Operation
- Accept = req_valid & req_ready; req_ready = !fifo_full & !rstn. A push is never allowed when full, even if a pop occurs in the same cycle.
- Encoding:
  - R: {alt?0100000:0, rs2, rs1, f3, rd, 0110011}
  - I_ALU: {imm[11:0], rs1, f3, rd, 0010011}
  - SHIFT_I: {alt?0100000:0, imm[4:0], rs1, f3, rd, 0010011}
  - LW: I-type, op 0000011, f3 010
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - BRANCH: B-type, op 1100011
  - JAL: J-type, op 1101111
  - JALR: I-type, f3 000, op 1100111
- Legality checks:
  - I/S kinds: imm[31:11] all equal.
  - BRANCH: imm[31:12] all equal, imm[0]=0, f3 ∉ {010, 011}.
  - JAL: imm[31:20] all equal, imm[0]=0.
  - SHIFT_I: imm[31:5]=0, f3 ∈ {001, 101}, alt only with 101.
  - R: alt only with f3 000/101.
- Illegal request: accepted, err←1, not pushed (see Configuration).
- Writer: mem_we = !fifo_empty; mem_wdata/mem_addr present the FIFO head. When mem_we & mem_ready, pop the head, mem_addr←mem_addr+1 (wraps modulo 2^ADDR_W), and wr_count increments, saturating at 0xFFFF.
- base_load: mem_addr←base_addr. It overrides a same-cycle increment and affects only the next write; queued entries are kept.
- Reset values: req_ready 0 while reset asserted, FIFO empty, mem_we 0, mem_addr 0, mem_wdata 0, err 0, wr_count 0. Reset mid-burst discards queued entries.

## Timing
- Accept at edge N → mem_we high in cycle N+1 when the FIFO was empty. Accept-to-write latency is 1 cycle minimum.
- Throughput is 1 instruction/cycle with mem_ready held high.
- mem_wdata/mem_addr stay stable while mem_we & !mem_ready.
- req_ready drops in the cycle after the DEPTH-th unpopped accept. It rises in the cycle after a pop from full.
- err is set in the cycle after the illegal accept and clears only on reset.

## Configuration
- INST_ENC_NOP_PAD_EN defined: an illegal request pushes NOP 0x00000013 (addi x0,x0,0), so the address sequence stays aligned with the request sequence; err is still set.
- Not defined: illegal requests are dropped and nothing is written.

## Structure
- Shared package: kind encodings, opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111), NOP word.
- Sub-module inst_enc_fifo: DEPTH×32 synchronous FIFO with full/empty. Encoding and legality logic stay in the top level.

## Test plan
- I_ALU f3=000 rd=1 rs1=0 imm=5 → one write of 0x00500093 at addr 0, mem_we in the cycle after accept.
- R alt=1 f3=000 rd=3 rs1=1 rs2=2 → 0x402081B3; SW rs1=1 rs2=2 imm=8 → 0x0020A423 at the next address.
- BRANCH f3=000 rs1=1 rs2=2 imm=-4 → 0xFE208EE3.
- mem_ready=0, push 5 requests → req_ready low after the 4th. Release mem_ready → addrs 0–3 written in order, then the 5th at 4.
- base_load base_addr=0x3FF, two requests → writes at 0x3FF then 0x000; wr_count=2.
- JAL imm=3 → err=1 and no write. With INST_ENC_NOP_PAD_EN, 0x00000013 is written instead and the address advances.
